fifo_param: RTL and testbench

Parametrised synchronous FIFO that replaces the externally-pointed 8x10 memory in the transaction layer. It owns its write/read pointers, occupancy counter and status flags, with configurable data width, depth and almost-full/almost-empty thresholds. It sits between the transaction-layer producer and the downstream consumer.

---
 rtl/fifo_param.sv | 88 ++++++++
 tb/tb_fifo_param.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/fifo_param.sv
// Parametrised synchronous FIFO with internal pointers, occupancy count and status flags.
// Define FIFO_ERR_EN to add the sticky err_overflow / err_underflow outputs.
module fifo_param #(
  parameter int DATA_W = 10,
  parameter int ADDR_W = 3,
  parameter int AF_TH  = 6,
  parameter int AE_TH  = 2
) (
  input  logic              clk,
  input  logic              reset_L,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] data_in,
  input  logic              rd_en,
  output logic [DATA_W-1:0] data_out,
  output logic              valid_out,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic              almost_empty,
`ifdef FIFO_ERR_EN
  output logic              err_overflow,
  output logic              err_underflow,
`endif
  output logic [ADDR_W:0]   count
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W:0]   DEPTH_C = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0]   AF_C    = (ADDR_W+1)'(AF_TH);
  localparam logic [ADDR_W:0]   AE_C    = (ADDR_W+1)'(AE_TH);
  localparam logic [ADDR_W:0]   CNT_ONE = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] PTR_ONE = ADDR_W'(1);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic              rd_acc;
  logic              wr_acc;

  assign full         = (count == DEPTH_C);
  assign empty        = (count == '0);
  assign almost_full  = (count >= AF_C);
  assign almost_empty = (count <= AE_C);

  // A full FIFO still takes a write when the same edge pops a word.
  assign rd_acc = rd_en & ~empty;
  assign wr_acc = wr_en & (~full | rd_acc);

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (wr_acc) mem[wr_ptr] <= data_in;
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      data_out  <= '0;
      valid_out <= 1'b0;
    end else begin
      valid_out <= rd_acc;
      if (wr_acc) wr_ptr <= wr_ptr + PTR_ONE;
      if (rd_acc) begin
        rd_ptr   <= rd_ptr + PTR_ONE;
        data_out <= mem[rd_ptr];
      end
      case ({wr_acc, rd_acc})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

`ifdef FIFO_ERR_EN
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      err_overflow  <= 1'b0;
      err_underflow <= 1'b0;
    end else begin
      if (wr_en & full & ~rd_en) err_overflow  <= 1'b1;
      if (rd_en & empty)         err_underflow <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_fifo_param.sv
// Self-checking bench for fifo_param: vector table plus scoreboard queue and
// hand-written sequences for wrap-around, streaming and asynchronous reset.
module tb_fifo_param;

  localparam int DW    = 10;
  localparam int DEPTH = 8;

  logic          clk = 1'b0;
  logic          reset_L;
  logic          wr_en;
  logic [DW-1:0] data_in;
  logic          rd_en;
  logic [DW-1:0] data_out;
  logic          valid_out;
  logic          full;
  logic          empty;
  logic          almost_full;
  logic          almost_empty;
  logic [3:0]    count;
`ifdef FIFO_ERR_EN
  logic          err_overflow;
  logic          err_underflow;
`endif

  fifo_param #(.DATA_W(DW), .ADDR_W(3), .AF_TH(6), .AE_TH(2)) dut (
    .clk          (clk),
    .reset_L      (reset_L),
    .wr_en        (wr_en),
    .data_in      (data_in),
    .rd_en        (rd_en),
    .data_out     (data_out),
    .valid_out    (valid_out),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
`ifdef FIFO_ERR_EN
    .err_overflow (err_overflow),
    .err_underflow(err_underflow),
`endif
    .count        (count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          wr;
    logic          rd;
    logic [DW-1:0] din;
    int            exp_cnt;
    int            exp_valid;
  } vec_t;

  vec_t          vecs[$];
  logic [DW-1:0] sb[$];
  int            m_cnt;
  logic [DW-1:0] last_data;
  logic          m_ovf;
  logic          m_udf;
  int            checks;
  int            failures;

  function automatic vec_t mk(logic w, logic r, logic [DW-1:0] d, int c, int v);
    vec_t t;
    t.wr = w; t.rd = r; t.din = d; t.exp_cnt = c; t.exp_valid = v;
    return t;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_flags();
    check("count", 32'(count), 32'(m_cnt));
    check("full", 32'(full), 32'(m_cnt == DEPTH));
    check("empty", 32'(empty), 32'(m_cnt == 0));
    check("almost_full", 32'(almost_full), 32'(m_cnt >= 6));
    check("almost_empty", 32'(almost_empty), 32'(m_cnt <= 2));
`ifdef FIFO_ERR_EN
    check("err_overflow", 32'(err_overflow), 32'(m_ovf));
    check("err_underflow", 32'(err_underflow), 32'(m_udf));
`endif
  endtask

  // One clock cycle of stimulus; exp_cnt/exp_valid of -1 mean "use the model only".
  task automatic step(input logic w, input logic r, input logic [DW-1:0] d,
                      input int exp_cnt, input int exp_valid);
    logic racc;
    logic wacc;
    racc = r && (m_cnt != 0);
    wacc = w && ((m_cnt != DEPTH) || racc);
    if (w && !r && m_cnt == DEPTH) m_ovf = 1'b1;
    if (r && m_cnt == 0) m_udf = 1'b1;
    if (wacc) sb.push_back(d);
    wr_en = w; rd_en = r; data_in = d;
    @(posedge clk); #1;
    wr_en = 1'b0; rd_en = 1'b0;
    m_cnt = m_cnt + (wacc ? 1 : 0) - (racc ? 1 : 0);
    if (racc) last_data = sb.pop_front();
    check("valid_out", 32'(valid_out), 32'(racc));
    check("data_out", 32'(data_out), 32'(last_data));
    if (exp_cnt >= 0)   check("count_tbl", 32'(count), 32'(exp_cnt));
    if (exp_valid >= 0) check("valid_tbl", 32'(valid_out), 32'(exp_valid));
    check_flags();
  endtask

  task automatic model_reset();
    sb.delete();
    m_cnt = 0; last_data = '0; m_ovf = 1'b0; m_udf = 1'b0;
  endtask

  initial begin
    checks = 0; failures = 0;
    reset_L = 1'b0; wr_en = 1'b0; rd_en = 1'b0; data_in = '0;
    model_reset();

    repeat (2) @(posedge clk);
    #1;
    check("reset_valid", 32'(valid_out), 32'd0);
    check("reset_data", 32'(data_out), 32'd0);
    check_flags();
    reset_L = 1'b1;

    // Fill, overflow, full-simultaneous, drain, underflow, empty-simultaneous.
    for (int i = 1; i <= 8; i++) vecs.push_back(mk(1'b1, 1'b0, DW'(i), i, 0));
    vecs.push_back(mk(1'b1, 1'b0, 10'h0AA, 8, 0));
    vecs.push_back(mk(1'b1, 1'b1, 10'h0BB, 8, 1));
    for (int i = 7; i >= 0; i--) vecs.push_back(mk(1'b0, 1'b1, '0, i, 1));
    vecs.push_back(mk(1'b0, 1'b1, '0, 0, 0));
    vecs.push_back(mk(1'b1, 1'b1, 10'h155, 1, 0));
    vecs.push_back(mk(1'b0, 1'b1, '0, 0, 1));
    vecs.push_back(mk(1'b0, 1'b0, '0, 0, 0));

    foreach (vecs[i]) step(vecs[i].wr, vecs[i].rd, vecs[i].din, vecs[i].exp_cnt, vecs[i].exp_valid);

    // Wrap-around with interleaved reads, then drain.
    for (int i = 0; i < 20; i++) step(1'b1, (i % 3) != 0, DW'(10'h200 + i), -1, -1);
    for (int i = 0; i < 10 && m_cnt > 0; i++) step(1'b0, 1'b1, '0, -1, 1);
    check("drained", 32'(m_cnt), 32'd0);

    // Steady streaming at partial occupancy keeps count constant.
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, DW'(10'h300 + i), i + 1, 0);
    for (int i = 0; i < 10; i++) step(1'b1, 1'b1, DW'(10'h310 + i), 3, 1);

    // Asynchronous reset in the middle of a cycle with count=5.
    step(1'b1, 1'b0, 10'h3A0, 4, 0);
    step(1'b1, 1'b0, 10'h3A1, 5, 0);
    #2 reset_L = 1'b0;
    #1;
    model_reset();
    check("async_valid", 32'(valid_out), 32'd0);
    check("async_data", 32'(data_out), 32'd0);
    check_flags();
    @(posedge clk); #1;
    reset_L = 1'b1;
    step(1'b0, 1'b1, '0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
